// File: rtl/fifo_pkg.sv
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared sizing helpers and status type for the FIFO control stage
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int unsigned C_DEFAULT_AW = 3;

    function automatic int unsigned fifo_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // One extra bit so that a completely full FIFO (count == depth) is representable
    function automatic int unsigned fifo_cnt_w(input int unsigned aw);
        return aw + 32'd1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

`default_nettype wire

// File: rtl/fifo_if.sv
// ============================================================================
//  Module      : fifo_if
//  Description : User-side request and status bundle of the FIFO control stage
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fifo_if #(
    parameter int unsigned no_of_words = 3
) ();

    logic                   wr;
    logic                   rd;
    logic                   clr_err;
    logic                   w_en;
    logic [no_of_words-1:0] w_addr;
    logic [no_of_words-1:0] r_addr;
    logic                   full;
    logic                   empty;
    logic                   almost_full;
    logic                   almost_empty;
    logic [no_of_words:0]   count;
    logic                   overflow;
    logic                   underflow;

    modport master (
        output wr, rd, clr_err,
        input  w_en, w_addr, r_addr, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr, rd, clr_err,
        output w_en, w_addr, r_addr, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

`default_nettype wire

// File: rtl/fifo_ptr.sv
// ============================================================================
//  Module      : fifo_ptr
//  Description : Wrapping address pointer with increment enable
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_ptr #(
    parameter int unsigned W = 3
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         inc,
    output logic [W-1:0]      ptr
);

    localparam logic [W-1:0] c_one = W'(1);

    logic [W-1:0] r_ptr;

    // Wraps from depth-1 back to 0 through natural binary overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= r_ptr + c_one;
        end
    end

    assign ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/fifo_ctrl.sv
// ============================================================================
//  Module      : fifo_ctrl
//  Description : FIFO pointer, occupancy, status and sticky-error control stage
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned no_of_words = 3,
    parameter int unsigned af_margin   = 1,
    parameter int unsigned ae_margin   = 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    fifo_if.slave     bus
);

    localparam int unsigned    c_depth  = fifo_depth(no_of_words);
    localparam int unsigned    c_cw     = fifo_cnt_w(no_of_words);
    localparam logic [c_cw-1:0] c_one    = c_cw'(1);
    localparam logic [c_cw-1:0] c_full   = c_cw'(c_depth);
    localparam logic [c_cw-1:0] c_af_th  = c_cw'(c_depth - af_margin);
    localparam logic [c_cw-1:0] c_ae_th  = c_cw'(ae_margin);

    // Reset flags are the flag equations evaluated at count == 0
    localparam fifo_status_t c_status_rst = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  (af_margin >= c_depth),
        almost_empty: 1'b1,
        overflow:     1'b0,
        underflow:    1'b0
    };

    logic                   w_do_rd;
    logic                   w_do_wr;
    logic [c_cw-1:0]        w_next_count;
    fifo_status_t           w_next_status;
    logic [c_cw-1:0]        r_count;
    fifo_status_t           r_status;
    logic [no_of_words-1:0] w_wr_ptr;
    logic [no_of_words-1:0] w_rd_ptr;

    // A pop on a full FIFO frees the slot this push lands in
    always_comb begin
        w_do_rd = bus.rd & ~r_status.empty;
        w_do_wr = bus.wr & (~r_status.full | bus.rd);
    end

    always_comb begin
        w_next_count = r_count;
        case ({w_do_wr, w_do_rd})
            2'b10:   w_next_count = r_count + c_one;
            2'b01:   w_next_count = r_count - c_one;
            default: w_next_count = r_count;
        endcase
    end

    always_comb begin
        w_next_status              = r_status;
        w_next_status.full         = (w_next_count == c_full);
        w_next_status.empty        = (w_next_count == '0);
        w_next_status.almost_full  = (w_next_count >= c_af_th);
        w_next_status.almost_empty = (w_next_count <= c_ae_th);
        // A fresh error outranks a clear in the same cycle
        w_next_status.overflow     = (bus.wr & ~w_do_wr) | (r_status.overflow  & ~bus.clr_err);
        w_next_status.underflow    = (bus.rd & ~w_do_rd) | (r_status.underflow & ~bus.clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_status <= c_status_rst;
        end else begin
            r_count  <= w_next_count;
            r_status <= w_next_status;
        end
    end

    fifo_ptr #(
        .W (no_of_words)
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_do_wr),
        .ptr   (w_wr_ptr)
    );

    fifo_ptr #(
        .W (no_of_words)
    ) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_do_rd),
        .ptr   (w_rd_ptr)
    );

    assign bus.w_en         = w_do_wr;
    assign bus.w_addr       = w_wr_ptr;
    assign bus.r_addr       = w_rd_ptr;
    assign bus.count        = r_count;
    assign bus.full         = r_status.full;
    assign bus.empty        = r_status.empty;
    assign bus.almost_full  = r_status.almost_full;
    assign bus.almost_empty = r_status.almost_empty;
    assign bus.overflow     = r_status.overflow;
    assign bus.underflow    = r_status.underflow;

endmodule

`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
// ============================================================================
//  Module      : tb_fifo_ctrl
//  Description : Randomised scoreboard bench for fifo_ctrl with a queue-based model
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_ctrl;

    localparam int unsigned c_aw    = 3;
    localparam int unsigned c_depth = 8;
    localparam int unsigned c_afm   = 1;
    localparam int unsigned c_aem   = 1;

    typedef struct {
        logic       wen;
        logic       rd_ok;
        logic [7:0] rdata;
        logic [3:0] cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       unf;
        logic [2:0] wa;
        logic [2:0] ra;
    } req_t;

    logic clk;
    logic rst_n;
    logic [7:0] wdata;
    logic [7:0] mem [c_depth];
    logic [7:0] rdata;

    int checks = 0;
    int errors = 0;

    req_t   exp_q [$];
    logic [7:0] mq [$];
    int     pushes = 0;
    int     pops   = 0;
    bit     m_ovf  = 0;
    bit     m_unf  = 0;
    logic [7:0] next_val = 8'h01;

    fifo_if #(.no_of_words(c_aw)) bus ();

    fifo_ctrl #(
        .no_of_words (c_aw),
        .af_margin   (c_afm),
        .ae_margin   (c_aem)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the register file: synchronous write, combinational read
    always @(posedge clk) if (bus.w_en) mem[bus.w_addr] <= wdata;
    assign rdata = mem[bus.r_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, 32'(bus.count), 0);
        chk({tag, "_empty"}, 32'(bus.empty), 1);
        chk({tag, "_full"}, 32'(bus.full), 0);
        chk({tag, "_ae"}, 32'(bus.almost_empty), 1);
        chk({tag, "_af"}, 32'(bus.almost_full), 0);
        chk({tag, "_waddr"}, 32'(bus.w_addr), 0);
        chk({tag, "_raddr"}, 32'(bus.r_addr), 0);
        chk({tag, "_ovf"}, 32'(bus.overflow), 0);
        chk({tag, "_unf"}, 32'(bus.underflow), 0);
    endtask

    task automatic model_reset();
        mq.delete();
        pushes = 0;
        pops   = 0;
        m_ovf  = 0;
        m_unf  = 0;
    endtask

    // One cycle of stimulus; the queue model derives the expected response
    task automatic step(input bit wr, input bit rd, input bit clr);
        req_t e;
        @(negedge clk);
        bus.wr      = wr;
        bus.rd      = rd;
        bus.clr_err = clr;
        wdata       = next_val;
        next_val    = next_val + 8'd1;
        e.wen   = wr && (mq.size() < c_depth || rd);
        e.rd_ok = rd && (mq.size() > 0);
        e.rdata = e.rd_ok ? mq[0] : 8'h00;
        if (e.rd_ok) begin
            void'(mq.pop_front());
            pops++;
        end
        if (e.wen) begin
            mq.push_back(wdata);
            pushes++;
        end
        m_ovf   = (wr && !e.wen) || (m_ovf && !clr);
        m_unf   = (rd && !e.rd_ok) || (m_unf && !clr);
        e.cnt   = 4'(mq.size());
        e.full  = (mq.size() == c_depth);
        e.empty = (mq.size() == 0);
        e.af    = (mq.size() >= c_depth - c_afm);
        e.ae    = (mq.size() <= c_aem);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.wa    = 3'(pushes % c_depth);
        e.ra    = 3'(pops % c_depth);
        exp_q.push_back(e);
    endtask

    // Monitor: combinational response before the edge, registered state after it
    initial begin
        req_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("w_en", 32'(bus.w_en), 32'(e.wen));
                if (e.rd_ok) chk("rdata", 32'(rdata), 32'(e.rdata));
                @(posedge clk);
                #1;
                chk("count", 32'(bus.count), 32'(e.cnt));
                chk("full", 32'(bus.full), 32'(e.full));
                chk("empty", 32'(bus.empty), 32'(e.empty));
                chk("almost_full", 32'(bus.almost_full), 32'(e.af));
                chk("almost_empty", 32'(bus.almost_empty), 32'(e.ae));
                chk("overflow", 32'(bus.overflow), 32'(e.ovf));
                chk("underflow", 32'(bus.underflow), 32'(e.unf));
                chk("w_addr", 32'(bus.w_addr), 32'(e.wa));
                chk("r_addr", 32'(bus.r_addr), 32'(e.ra));
            end
        end
    end

    initial begin
        int budget;
        int thr_w;
        int thr_r;
        rst_n       = 1'b0;
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        bus.clr_err = 1'b0;
        wdata       = 8'h00;
        #12;
        chk_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0);

        // Fill to full, overflow, clear, then push+pop while full
        for (int i = 0; i < 8; i++) step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        step(1, 1, 0);
        step(1, 1, 0);

        // Drain, then push+pop while empty, then the new entry is popped
        for (int i = 0; i < 8; i++) step(0, 1, 0);
        step(1, 1, 0);
        step(0, 1, 0);
        step(0, 1, 1);
        step(0, 0, 1);

        // Randomised phases with varying push/pop bias
        for (int p = 0; p < 4; p++) begin
            thr_w = (p == 0) ? 80 : (p == 1) ? 25 : 55;
            thr_r = (p == 0) ? 25 : (p == 1) ? 80 : 55;
            for (int i = 0; i < 100; i++) begin
                step($urandom_range(99, 0) < thr_w,
                     $urandom_range(99, 0) < thr_r,
                     $urandom_range(99, 0) < 10);
            end
        end

        // Fill to 5, then assert reset asynchronously in the middle of a cycle
        while (mq.size() < 5) step(1, 0, 0);
        while (mq.size() > 5) step(0, 1, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        @(negedge clk);
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        bus.clr_err = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async_rst");
        chk("async_rst_wen", 32'(bus.w_en), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) step($urandom_range(1, 0), $urandom_range(1, 0), 1'b0);

        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Control stage of the FIFO. It sits directly beside the FIFO register file and drives that file's w_en, write_address and read_address.
- It accepts push/pop requests from the FIFO user and maintains the write/read pointers, occupancy count, full/empty and almost-full/almost-empty status, and sticky overflow/underflow error flags.
- The register file's read port is combinational, so read data for the current r_addr is valid in the same cycle that rd is asserted.

Parameters:
- no_of_words, 3: address width in bits; FIFO depth is 2**no_of_words. Must be >= 1. Matches the register file parameter of the same name.
- af_margin, 1: almost_full asserts when count >= depth - af_margin. Range 0..depth.
- ae_margin, 1: almost_empty asserts when count <= ae_margin. Range 0..depth.

Ports:
- clk  in  1  clock, rising-edge active.
- rst_n  in  1  asynchronous active-low reset.
- wr  in  1  push request; data is presented to the register file by the user.
- rd  in  1  pop request; consumes the entry at r_addr.
- clr_err  in  1  synchronous clear of the sticky overflow and underflow flags.
- w_en  out  1  write enable to the register file (combinational).
- w_addr  out  no_of_words  write address to the register file (registered wr_ptr).
- r_addr  out  no_of_words  read address to the register file (registered rd_ptr).
- full  out  1  registered.
- empty  out  1  registered.
- almost_full  out  1  registered.
- almost_empty  out  1  registered.
- count  out  no_of_words+1  occupancy, registered, range 0..depth.
- overflow  out  1  sticky; a push was rejected.
- underflow  out  1  sticky; a pop was rejected.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, almost_empty=1, almost_full=(af_margin>=depth).
  - overflow=0, underflow=0.
- Acceptance (combinational):
  - do_rd = rd & ~empty.
  - do_wr = wr & (~full | rd). When full, a simultaneous pop frees the slot, so the push is accepted.
  - w_en = do_wr.
- Update on each rising clk edge:
  - If do_wr: wr_ptr += 1.
  - If do_rd: rd_ptr += 1.
  - Pointers wrap modulo 2**no_of_words, from depth-1 to 0, by natural overflow.
- Count:
  - do_wr only: count+1.
  - do_rd only: count-1.
  - both or neither: unchanged.
- Flags:
  - All flags are computed from next_count and registered, so they change in the cycle after the causing edge, aligned with count.
  - full = (next_count == depth); empty = (next_count == 0).
  - almost_full and almost_empty use the thresholds in Parameters, applied to next_count.
- Boundary conditions:
  - Empty with rd&wr: pop rejected, push accepted; count becomes 1; underflow sets.
  - Full with rd&wr: both accepted; count stays depth; full stays 1; no overflow.
  - Full with wr only: push rejected; w_en=0; overflow sets.
  - Empty with rd only: pop rejected; underflow sets.
- Sticky error flags:
  - overflow sets when wr & ~do_wr; underflow sets when rd & ~do_rd.
  - Both hold until clr_err=1 or reset.
  - If clr_err and a new error occur in the same cycle, the set wins.
- Write-read collision: when full with rd&wr, w_addr == r_addr. The current entry is read combinationally before the edge, then overwritten at the edge. This is legal and required.
- Reset mid-operation: all state returns to reset values immediately. Memory contents are not cleared and are don't-care.
- No other state machine: pointers plus count fully define state.

Decomposition:
- Package fifo_pkg:
  - localparam/functions for depth (2**no_of_words).
  - Count width no_of_words+1.
  - Typedef fifo_status_t: packed struct of full, empty, almost_full, almost_empty, overflow, underflow.
- One natural sub-module: fifo_ptr, a wrapping pointer with increment enable and async active-low reset, instantiated twice (write and read).
- A top wrapper fifo_top, containing fifo_ctrl plus the existing register file, is built separately and is not part of this block.

Test Plan (no_of_words=3 → depth 8, af_margin=1, ae_margin=1):
- Reset then idle → count=0, empty=1, full=0, almost_empty=1, w_addr=0, r_addr=0, all error flags 0.
- 8 consecutive wr → w_en=1 each cycle; count steps 1..8; almost_full at count=7; full=1 at count 8; w_addr wraps back to 0.
- 9th wr while full → w_en=0, count stays 8, overflow=1 and holds; clr_err pulse → overflow=0.
- Full, then rd&wr in the same cycle → w_en=1, count stays 8, r_addr and w_addr both advance by 1; read data equals the oldest entry.
- Empty with rd&wr → w_en=1, count=1, r_addr unchanged, underflow=1; next cycle rd only → count=0, empty=1.
- Fill to 5, assert rst_n=0 asynchronously mid-cycle → all outputs return to reset values before the next clk edge.
